// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - icache/dcache read request, return and AXI read channel bundle
interface axi_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_r_req;
    logic                  d_r_req;
    logic [ADDR_WIDTH-1:0] i_r_addr;
    logic [ADDR_WIDTH-1:0] d_r_addr;
    logic [7:0]            i_r_length;
    logic [7:0]            d_r_length;
    logic [2:0]            i_r_size;
    logic [2:0]            d_r_size;
    logic                  i_r_rdy;
    logic                  d_r_rdy;
    logic                  i_r_data_ready;
    logic                  d_r_data_ready;
    logic                  i_ret_valid;
    logic                  d_ret_valid;
    logic                  i_ret_last;
    logic                  d_ret_last;
    logic [DATA_WIDTH-1:0] ret_data;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [3:0]            arid;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;

    logic                  arb_err;

    modport master (
        input  i_r_req, d_r_req, i_r_addr, d_r_addr, i_r_length, d_r_length,
               i_r_size, d_r_size, i_r_data_ready, d_r_data_ready,
               arready, rvalid, rdata, rlast,
        output i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last,
               ret_data, arvalid, araddr, arlen, arsize, arid, rready, arb_err
    );

    modport slave (
        output i_r_req, d_r_req, i_r_addr, d_r_addr, i_r_length, d_r_length,
               i_r_size, d_r_size, i_r_data_ready, d_r_data_ready,
               arready, rvalid, rdata, rlast,
        input  i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last,
               ret_data, arvalid, araddr, arlen, arsize, arid, rready, arb_err
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - single-outstanding icache/dcache AXI read arbiter; CLAP_ARB_RR_EN selects round-robin tie-break
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    axi_rd_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t                r_state;
    logic                  r_gnt_d;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [7:0]            r_beat;
    logic                  r_err;
`ifdef CLAP_ARB_RR_EN
    logic                  r_last_d;
`endif

    logic                  w_any_req;
    logic                  w_pick_d;
    logic                  w_in_addr;
    logic                  w_in_data;
    logic                  w_data_ready;
    logic                  w_beat_acc;
    logic [DATA_WIDTH-1:0] w_ret_data;

    assign w_any_req = bus.i_r_req | bus.d_r_req;

    always_comb begin
        w_pick_d = bus.d_r_req;
`ifdef CLAP_ARB_RR_EN
        if (bus.i_r_req && bus.d_r_req) begin
            w_pick_d = ~r_last_d;
        end
`endif
    end

    assign w_in_addr    = (r_state == ST_ADDR);
    assign w_in_data    = (r_state == ST_DATA);
    assign w_data_ready = r_gnt_d ? bus.d_r_data_ready : bus.i_r_data_ready;
    assign w_beat_acc   = w_in_data & bus.rvalid & w_data_ready;
    assign w_ret_data   = bus.rdata;

    assign bus.arvalid     = w_in_addr;
    assign bus.araddr      = w_in_addr ? r_addr : '0;
    assign bus.arlen       = w_in_addr ? r_len  : '0;
    assign bus.arsize      = w_in_addr ? r_size : '0;
    assign bus.arid        = {3'b000, w_in_addr & r_gnt_d};
    assign bus.i_r_rdy     = w_in_addr & bus.arready & ~r_gnt_d;
    assign bus.d_r_rdy     = w_in_addr & bus.arready &  r_gnt_d;
    assign bus.rready      = w_in_data & w_data_ready;
    assign bus.i_ret_valid = w_in_data & ~r_gnt_d & bus.rvalid;
    assign bus.d_ret_valid = w_in_data &  r_gnt_d & bus.rvalid;
    assign bus.i_ret_last  = w_in_data & ~r_gnt_d & bus.rvalid & bus.rlast;
    assign bus.d_ret_last  = w_in_data &  r_gnt_d & bus.rvalid & bus.rlast;
    assign bus.ret_data    = w_ret_data;
    assign bus.arb_err     = r_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_gnt_d  <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_beat   <= '0;
            r_err    <= 1'b0;
`ifdef CLAP_ARB_RR_EN
            r_last_d <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_d  <= w_pick_d;
                        r_addr   <= w_pick_d ? bus.d_r_addr   : bus.i_r_addr;
                        r_len    <= w_pick_d ? bus.d_r_length : bus.i_r_length;
                        r_size   <= w_pick_d ? bus.d_r_size   : bus.i_r_size;
                        r_state  <= ST_ADDR;
`ifdef CLAP_ARB_RR_EN
                        r_last_d <= w_pick_d;
`endif
                    end
                end
                ST_ADDR: begin
                    if (bus.arready) begin
                        r_beat  <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat_acc) begin
                        r_beat <= r_beat + 8'd1;
                        // rlast must coincide exactly with the beat whose index equals the latched length
                        if (bus.rlast != (r_beat == r_len)) begin
                            r_err <= 1'b1;
                        end
                        if (bus.rlast) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed vector bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        int          last_at;
        int          stall_at;
        int          ar_wait;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];
    int   n_pass = 0;
    int   n_total = 0;

    int   ar_cnt = 0, i_rdy_cnt = 0, d_rdy_cnt = 0;
    int   i_beat_cnt = 0, d_beat_cnt = 0, i_last_cnt = 0, d_last_cnt = 0;
    int   last_beat_idx = 0, stall_viol = 0, leak_cnt = 0;
    logic [3:0]  last_arid = '0;
    logic [31:0] last_araddr = '0;
    logic [7:0]  last_arlen = '0;
    logic [2:0]  last_arsize = '0;
    bit   stalling = 1'b0;

    always @(posedge clk) begin
        if (bus.arvalid && bus.arready) begin
            ar_cnt      <= ar_cnt + 1;
            last_arid   <= bus.arid;
            last_araddr <= bus.araddr;
            last_arlen  <= bus.arlen;
            last_arsize <= bus.arsize;
        end
        if (bus.i_r_rdy) i_rdy_cnt <= i_rdy_cnt + 1;
        if (bus.d_r_rdy) d_rdy_cnt <= d_rdy_cnt + 1;
        if (bus.i_ret_valid && bus.i_r_data_ready) begin
            i_beat_cnt <= i_beat_cnt + 1;
            if (bus.i_ret_last) begin
                i_last_cnt    <= i_last_cnt + 1;
                last_beat_idx <= i_beat_cnt + 1;
            end
        end
        if (bus.d_ret_valid && bus.d_r_data_ready) begin
            d_beat_cnt <= d_beat_cnt + 1;
            if (bus.d_ret_last) begin
                d_last_cnt    <= d_last_cnt + 1;
                last_beat_idx <= d_beat_cnt + 1;
            end
        end
        if (stalling && bus.rready) stall_viol <= stall_viol + 1;
        if ((bus.i_ret_valid && bus.d_ret_valid) || (bus.i_r_rdy && bus.d_r_rdy)) leak_cnt <= leak_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int  ar0, ir0, dr0, ib0, db0, il0, dl0, b, stall_left;
        bit  got_ar, done;
        string tag;
        tag = $sformatf("v%0d", idx);
        ar0 = ar_cnt; ir0 = i_rdy_cnt; dr0 = d_rdy_cnt;
        ib0 = i_beat_cnt; db0 = d_beat_cnt; il0 = i_last_cnt; dl0 = d_last_cnt;
        bus.i_r_data_ready = 1'b1;
        bus.d_r_data_ready = 1'b1;
        if (v.is_d) begin
            bus.d_r_req = 1'b1; bus.d_r_addr = v.addr; bus.d_r_length = v.len; bus.d_r_size = v.size;
        end else begin
            bus.i_r_req = 1'b1; bus.i_r_addr = v.addr; bus.i_r_length = v.len; bus.i_r_size = v.size;
        end
        got_ar = 1'b0;
        for (int n = 0; n < 8 && !got_ar; n++) begin
            @(negedge clk);
            got_ar = bus.arvalid;
        end
        chk({tag, " arvalid"}, 64'(got_ar), 64'd1);
        repeat (v.ar_wait) @(negedge clk);
        bus.arready = 1'b1;
        @(posedge clk); #1;
        bus.arready = 1'b0;
        bus.i_r_req = 1'b0;
        bus.d_r_req = 1'b0;

        b = 0; done = 1'b0; stall_left = 3;
        for (int n = 0; n < 64 && !done; n++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = v.addr + 32'(b);
            bus.rlast  = (b == v.last_at);
            stalling   = (b == v.stall_at) && (stall_left > 0);
            if (stalling) stall_left--;
            if (v.is_d) bus.d_r_data_ready = !stalling;
            else        bus.i_r_data_ready = !stalling;
            if (n == 0) begin
                @(negedge clk);
                chk({tag, " ret_data"}, 64'(bus.ret_data), 64'(v.addr));
            end
            @(posedge clk); #1;
            if (!stalling) begin
                if (bus.rlast) done = 1'b1;
                b++;
            end
        end
        bus.rvalid = 1'b0; bus.rlast = 1'b0; stalling = 1'b0;
        bus.i_r_data_ready = 1'b1; bus.d_r_data_ready = 1'b1;

        chk({tag, " done"},       64'(done), 64'd1);
        chk({tag, " ar_count"},   64'(ar_cnt - ar0), 64'd1);
        chk({tag, " arid"},       64'(last_arid), v.is_d ? 64'd1 : 64'd0);
        chk({tag, " araddr"},     64'(last_araddr), 64'(v.addr));
        chk({tag, " arlen"},      64'(last_arlen), 64'(v.len));
        chk({tag, " arsize"},     64'(last_arsize), 64'(v.size));
        chk({tag, " own_rdy"},    64'(v.is_d ? d_rdy_cnt - dr0 : i_rdy_cnt - ir0), 64'd1);
        chk({tag, " other_rdy"},  64'(v.is_d ? i_rdy_cnt - ir0 : d_rdy_cnt - dr0), 64'd0);
        chk({tag, " own_beats"},  64'(v.is_d ? d_beat_cnt - db0 : i_beat_cnt - ib0), 64'(v.last_at + 1));
        chk({tag, " other_beats"}, 64'(v.is_d ? i_beat_cnt - ib0 : d_beat_cnt - db0), 64'd0);
        chk({tag, " own_last"},   64'(v.is_d ? d_last_cnt - dl0 : i_last_cnt - il0), 64'd1);
        chk({tag, " last_beat"},  64'(last_beat_idx), 64'((v.is_d ? db0 : ib0) + v.last_at + 1));
        chk({tag, " arb_err"},    64'(bus.arb_err), 64'(v.exp_err));
        chk({tag, " stall_rready"}, 64'(stall_viol), 64'd0);
        chk({tag, " leak"},       64'(leak_cnt), 64'd0);
    endtask

    task automatic arb_seq(input string tag, input int d_reqs, input int i_reqs, input int n,
                           output logic [7:0] seq);
        int dl, il;
        bit got;
        dl = d_reqs; il = i_reqs; seq = '0;
        bus.d_r_addr = 32'h0000_d000; bus.d_r_length = 8'd0; bus.d_r_size = 3'd2;
        bus.i_r_addr = 32'h0000_1000; bus.i_r_length = 8'd0; bus.i_r_size = 3'd2;
        bus.d_r_req = (dl > 0);
        bus.i_r_req = (il > 0);
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                @(negedge clk);
                got = bus.arvalid;
            end
            chk($sformatf("%s grant%0d seen", tag, k), 64'(got), 64'd1);
            seq[k] = bus.arid[0];
            bus.arready = 1'b1;
            @(posedge clk); #1;
            bus.arready = 1'b0;
            if (seq[k]) begin dl--; bus.d_r_req = (dl > 0); end
            else        begin il--; bus.i_r_req = (il > 0); end
            bus.rvalid = 1'b1; bus.rlast = 1'b1;
            @(posedge clk); #1;
            bus.rvalid = 1'b0; bus.rlast = 1'b0;
        end
        bus.d_r_req = 1'b0;
        bus.i_r_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq;
        bit got;

        vecs[0] = '{1'b1, 32'h1000_0040, 8'd15, 3'd2, 15, -1, 0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_2000, 8'd3,  3'd2, 3,  -1, 2, 1'b0};
        vecs[2] = '{1'b1, 32'h2000_0100, 8'd15, 3'd2, 15, 6,  0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_3004, 8'd0,  3'd2, 0,  -1, 1, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_4000, 8'd3,  3'd2, 1,  -1, 0, 1'b1};
        vecs[5] = '{1'b1, 32'h3000_0000, 8'd1,  3'd1, 1,  -1, 0, 1'b1};

        bus.i_r_req = 0; bus.d_r_req = 0;
        bus.i_r_addr = '0; bus.d_r_addr = '0;
        bus.i_r_length = '0; bus.d_r_length = '0;
        bus.i_r_size = '0; bus.d_r_size = '0;
        bus.i_r_data_ready = 1; bus.d_r_data_ready = 1;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rlast = 0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("reset arvalid", 64'(bus.arvalid), 64'd0);
        chk("reset rready",  64'(bus.rready), 64'd0);
        chk("reset rdy",     64'({bus.i_r_rdy, bus.d_r_rdy}), 64'd0);
        chk("reset ret",     64'({bus.i_ret_valid, bus.d_ret_valid, bus.i_ret_last, bus.d_ret_last}), 64'd0);
        chk("reset arb_err", 64'(bus.arb_err), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

        // reset lands on beat index 5 of a dcache burst
        bus.d_r_req = 1; bus.d_r_addr = 32'h1000_0040; bus.d_r_length = 8'd15; bus.d_r_size = 3'd2;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            @(negedge clk);
            got = bus.arvalid;
        end
        chk("rst arvalid", 64'(got), 64'd1);
        bus.arready = 1;
        @(posedge clk); #1;
        bus.arready = 0; bus.d_r_req = 0;
        for (int b = 0; b < 5; b++) begin
            bus.rvalid = 1; bus.rlast = 0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst pre rready", 64'(bus.rready), 64'd1);
        chk("rst pre arb_err", 64'(bus.arb_err), 64'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst rready",    64'(bus.rready), 64'd0);
        chk("rst ret_valid", 64'(bus.d_ret_valid), 64'd0);
        chk("rst arvalid0",  64'(bus.arvalid), 64'd0);
        chk("rst arb_err",   64'(bus.arb_err), 64'd0);
        @(posedge clk); #1;
        bus.rvalid = 0;
        run_txn(6, vecs[1]);

        arb_seq("pair1", 1, 1, 2, seq);
        chk("pair1 order", 64'(seq[1:0]), 64'b01);
        arb_seq("pair2", 1, 1, 2, seq);
        chk("pair2 order", 64'(seq[1:0]), 64'b01);
        arb_seq("btb3", 3, 1, 4, seq);
`ifdef CLAP_ARB_RR_EN
        chk("btb3 order", 64'(seq[3:0]), 64'b1101);
`else
        chk("btb3 order", 64'(seq[3:0]), 64'b0111);
`endif
        chk("final leak", 64'(leak_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all read addresses.
REQ-002 Parameter DATA_WIDTH, default 32, width of rdata and ret_data.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port rstn  in  1  reset, synchronous, active-low.
REQ-005 Ports i_r_req / d_r_req  in  1  icache / dcache read request, held high until the matching x_r_rdy.
REQ-006 Ports i_r_addr / d_r_addr  in  ADDR_WIDTH  request address, stable while req is high.
REQ-007 Ports i_r_length / d_r_length  in  8  burst beats minus 1.
REQ-008 Ports i_r_size / d_r_size  in  3  AXI beat size code.
REQ-009 Ports i_r_rdy / d_r_rdy  out  1  one-cycle pulse on address acceptance.
REQ-010 Ports i_r_data_ready / d_r_data_ready  in  1  requester can accept a beat.
REQ-011 Ports i_ret_valid / d_ret_valid  out  1  beat valid for that requester.
REQ-012 Ports i_ret_last / d_ret_last  out  1  final beat for that requester.
REQ-013 Port ret_data  out  DATA_WIDTH  shared return data, equals rdata.
REQ-014 Ports arvalid out 1, arready in 1, araddr out ADDR_WIDTH, arlen out 8, arsize out 3, arid out 4  AXI read-address channel.
REQ-015 Ports rvalid in 1, rready out 1, rdata in DATA_WIDTH, rlast in 1  AXI read-data channel.
REQ-016 Port arb_err  out  1  sticky protocol-error flag.

Function
REQ-017 States: IDLE, ADDR, DATA. Exactly one transaction is outstanding at a time.
REQ-018 IDLE, any req high: latch the winner's grant, addr, length, and size into registers, then go to ADDR next cycle. No req: stay in IDLE.
REQ-019 ADDR: arvalid=1. araddr, arlen, and arsize come from the latched registers. arid=0 for icache, 1 for dcache.
- arready=1: the granted x_r_rdy pulses in that cycle, and the state goes to DATA.
- arready=0: hold.
REQ-020 DATA: rready = granted x_r_data_ready. Granted x_ret_valid = rvalid. Granted x_ret_last = rvalid & rlast. The non-granted requester's outputs stay 0.
REQ-021 DATA, rvalid&rready&rlast: go to IDLE next cycle. A new grant is possible in that IDLE cycle, so the minimum gap between AR handshakes is 2 cycles.
REQ-022 8-bit beat counter: cleared on ADDR->DATA, incremented on each rvalid&rready.
REQ-023 arb_err is set when either condition holds, and holds until reset:
- rlast is accepted with beat counter != latched length;
- a beat is accepted with beat counter == latched length and rlast=0.
The transaction still completes on rlast.
REQ-024 Request inputs are ignored outside IDLE. A request that arrives late stays pending until the next IDLE.
REQ-025 Outputs are driven combinationally from state and latched registers only. x_r_rdy depends additionally on arready; rready depends additionally on x_r_data_ready.

Reset
REQ-026 When rstn=0 at a clock edge:
- state=IDLE; arb_err=0; last-grant=icache; beat counter=0;
- all outputs 0 in the following cycle;
- any in-flight transaction is abandoned without a completion pulse.

Configuration
REQ-027 Macro CLAP_ARB_RR_EN defined: simultaneous requests in IDLE go to the requester not granted last. Last-grant updates on each grant.
REQ-028 CLAP_ARB_RR_EN undefined: fixed priority, dcache always wins a tie, and the last-grant register is omitted.

Verification
REQ-029 Single dcache request, addr 0x1000_0040, length 15, size 2, arready=1 on the first ADDR cycle:
- arid=1, araddr=0x1000_0040, arlen=15;
- d_r_rdy pulses once;
- 16 d_ret_valid beats, d_ret_last on beat 16;
- arb_err=0.
REQ-030 Both requests in the same cycle, with CLAP_ARB_RR_EN:
- dcache granted first, then icache;
- after both complete, a second simultaneous pair grants dcache first again.
REQ-031 Without CLAP_ARB_RR_EN, three back-to-back simultaneous pairs: dcache is granted three times before any icache grant.
REQ-032 d_r_data_ready low for 3 cycles mid-burst: rready=0 in those cycles, no beat counted, burst completes with all 16 beats.
REQ-033 Uncached icache request, length 0, rlast driven on beat 1: i_ret_last=1 on beat 1, arb_err=0. Then a length-3 burst with rlast on beat 2: arb_err=1 and stays 1.
REQ-034 rstn pulled low during DATA beat 5: state returns to IDLE, rready=0 and arb_err=0 next cycle, and a new request is granted normally after reset.
